// File: rtl/lcd_pattern_gen_if.sv
// LCD panel pin bundle: the generator drives it (master), the panel consumes it (slave).
interface lcd_pattern_gen_if;
  logic [7:0] lcd_r;
  logic [7:0] lcd_g;
  logic [7:0] lcd_b;
  logic       lcd_hsync;
  logic       lcd_vsync;
  logic       lcd_de;
  logic       lcd_dclk;
  logic       lcd_disp;

  modport master (
    output lcd_r, lcd_g, lcd_b, lcd_hsync, lcd_vsync, lcd_de, lcd_dclk, lcd_disp
  );

  modport slave (
    input lcd_r, lcd_g, lcd_b, lcd_hsync, lcd_vsync, lcd_de, lcd_dclk, lcd_disp
  );
endinterface

// File: rtl/lcd_pattern_gen.sv
// Parametrised RGB LCD timing + test-pattern generator (bars, grey ramp, checker, solid).
// Define LCD_SCROLL_EN to scroll the ramp and checker patterns by one pixel per frame.
module lcd_pattern_gen #(
  parameter int unsigned H_ACTIVE        = 800,
  parameter int unsigned H_FP            = 40,
  parameter int unsigned H_SYNC          = 128,
  parameter int unsigned H_BP            = 88,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned V_FP            = 1,
  parameter int unsigned V_SYNC          = 3,
  parameter int unsigned V_BP            = 21,
  parameter int unsigned BAR_COUNT       = 8,
  parameter int unsigned CHECK_LOG2      = 5,
  parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     disp_en,
  input  logic [1:0]               mode,
  input  logic [23:0]              solid_rgb,
  lcd_pattern_gen_if.master        lcd,
  output logic [10:0]              pixel_x,
  output logic [9:0]               pixel_y,
  output logic                     frame_start,
  output logic [15:0]              frame_cnt
);

  localparam logic [11:0] H_LAST   = 12'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [11:0] H_SYN    = 12'(H_SYNC);
  localparam logic [11:0] H_BEG    = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_END    = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] H_ALAST  = 12'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [10:0] V_LAST   = 11'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [10:0] V_SYN    = 11'(V_SYNC);
  localparam logic [10:0] V_BEG    = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_END    = 11'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [11:0] BAR_W_M1 = 12'(H_ACTIVE / BAR_COUNT - 1);
  localparam logic [2:0]  BAR_LAST = 3'(BAR_COUNT - 1);
  localparam logic        SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pat_e;

  // Stage 0: timing counters and per-frame latched controls
  logic [11:0] h_cnt;
  logic [10:0] v_cnt;
  logic [11:0] bar_cnt;
  logic [2:0]  bar_idx;
  pat_e        mode_q;
  logic [23:0] solid_q;

  logic h_wrap, v_wrap, at_origin, h_act, v_act, de_c, hs_c, vs_c;
  logic [10:0] px_c, x_eff;
  logic [9:0]  py_c;
  logic [23:0] pat_rgb;

  assign h_wrap    = (h_cnt == H_LAST);
  assign v_wrap    = (v_cnt == V_LAST);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign h_act     = (h_cnt >= H_BEG) && (h_cnt < H_END);
  assign v_act     = (v_cnt >= V_BEG) && (v_cnt < V_END);
  assign de_c      = h_act && v_act;
  assign hs_c      = (h_cnt < H_SYN) ^ SYNC_IDLE;
  assign vs_c      = (v_cnt < V_SYN) ^ SYNC_IDLE;
  assign px_c      = de_c ? 11'(h_cnt - H_BEG) : '0;
  assign py_c      = de_c ? 10'(v_cnt - V_BEG) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      mode_q      <= PAT_BARS;
      solid_q     <= '0;
      bar_cnt     <= '0;
      bar_idx     <= '0;
    end else begin
      frame_start <= at_origin;
      if (at_origin) begin
        frame_cnt <= frame_cnt + 1'b1;
        mode_q    <= pat_e'(mode);
        solid_q   <= solid_rgb;
      end
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
      // Bar state tracks the current h_cnt; cleared outside the active span so
      // each line's first active pixel starts at bar 0.
      if (!h_act || (h_cnt == H_ALAST)) begin
        bar_cnt <= '0;
        bar_idx <= '0;
      end else if (bar_cnt == BAR_W_M1) begin
        bar_cnt <= '0;
        if (bar_idx != BAR_LAST) bar_idx <= bar_idx + 1'b1;
      end else begin
        bar_cnt <= bar_cnt + 1'b1;
      end
    end
  end

`ifdef LCD_SCROLL_EN
  logic [10:0] scroll, scroll_q;

  // scroll_q takes the pre-increment value, so the first frame is unscrolled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scroll   <= '0;
      scroll_q <= '0;
    end else if (at_origin) begin
      scroll   <= scroll + 1'b1;
      scroll_q <= scroll;
    end
  end

  assign x_eff = px_c + scroll_q;
`else
  assign x_eff = px_c;
`endif

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Stage 1: pattern compute
  always_comb begin
    pat_rgb = '0;
    case (mode_q)
      PAT_BARS:  pat_rgb = bar_colour(bar_idx);
      PAT_RAMP:  pat_rgb = {3{x_eff[7:0]}};
      PAT_CHECK: pat_rgb = (x_eff[CHECK_LOG2] ^ py_c[CHECK_LOG2]) ? '1 : '0;
      PAT_SOLID: pat_rgb = solid_q;
      default:   pat_rgb = '0;
    endcase
  end

  logic [23:0] s1_rgb, rgb_q;
  logic        s1_de, s1_hs, s1_vs, de_q, hs_q, vs_q, disp_q;
  logic [10:0] s1_x;
  logic [9:0]  s1_y;

  // Stage 1 and stage 2 registers; disp_en gates the final RGB register so the
  // blanking takes effect on the same edge as lcd_disp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rgb  <= '0;
      s1_de   <= 1'b0;
      s1_hs   <= SYNC_IDLE;
      s1_vs   <= SYNC_IDLE;
      s1_x    <= '0;
      s1_y    <= '0;
      rgb_q   <= '0;
      de_q    <= 1'b0;
      hs_q    <= SYNC_IDLE;
      vs_q    <= SYNC_IDLE;
      disp_q  <= 1'b0;
      pixel_x <= '0;
      pixel_y <= '0;
    end else begin
      s1_rgb  <= de_c ? pat_rgb : '0;
      s1_de   <= de_c;
      s1_hs   <= hs_c;
      s1_vs   <= vs_c;
      s1_x    <= px_c;
      s1_y    <= py_c;
      rgb_q   <= disp_en ? s1_rgb : '0;
      de_q    <= s1_de;
      hs_q    <= s1_hs;
      vs_q    <= s1_vs;
      disp_q  <= disp_en;
      pixel_x <= s1_x;
      pixel_y <= s1_y;
    end
  end

  assign lcd.lcd_r     = rgb_q[23:16];
  assign lcd.lcd_g     = rgb_q[15:8];
  assign lcd.lcd_b     = rgb_q[7:0];
  assign lcd.lcd_hsync = hs_q;
  assign lcd.lcd_vsync = vs_q;
  assign lcd.lcd_de    = de_q;
  assign lcd.lcd_disp  = disp_q;
  assign lcd.lcd_dclk  = ~clk;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Bench for lcd_pattern_gen on a small panel timing: arithmetic reference model plus literal anchors.
module tb_lcd_pattern_gen;
  localparam int HA = 16, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int BC = 3, CL = 1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;
  localparam int BW = HA / BC;
`ifdef LCD_SCROLL_EN
  localparam int SCROLL = 1;
`else
  localparam int SCROLL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        disp_en = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [23:0] solid_rgb = '0;
  logic [10:0] pixel_x;
  logic [9:0]  pixel_y;
  logic        frame_start;
  logic [15:0] frame_cnt;

  lcd_pattern_gen_if lcd();

  lcd_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BAR_COUNT(BC), .CHECK_LOG2(CL), .SYNC_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .disp_en(disp_en),
    .mode(mode),
    .solid_rgb(solid_rgb),
    .lcd(lcd),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .frame_start(frame_start),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pat(input int m, input int x, input int y,
                                      input logic [23:0] s, input int f);
    int b, xe;
    xe = (x + f * SCROLL) % 2048;
    case (m)
      0: begin
        b = x / BW;
        if (b > BC - 1) b = BC - 1;
        case (b)
          0:       return 24'hFFFFFF;
          1:       return 24'hFFFF00;
          2:       return 24'h00FFFF;
          3:       return 24'h00FF00;
          4:       return 24'hFF00FF;
          5:       return 24'hFF0000;
          6:       return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      1:       return {3{8'(xe % 256)}};
      2:       return ((((xe >> CL) ^ (y >> CL)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: return s;
    endcase
  endfunction

  // Edge bookkeeping: edges since reset release, inputs seen at each edge,
  // and the controls latched at the start of each frame.
  int          n_edge = 0;
  logic        disp_s = 1'b0;
  int          mode_of [0:255];
  logic [23:0] solid_of [0:255];

  always @(posedge clk) begin
    if (!rst_n) begin
      n_edge = 0;
    end else begin
      n_edge = n_edge + 1;
      disp_s = disp_en;
      if ((n_edge - 1) % FT == 0 && (n_edge - 1) / FT < 256) begin
        mode_of[(n_edge - 1) / FT]  = int'(mode);
        solid_of[(n_edge - 1) / FT] = solid_rgb;
      end
    end
  end

  int          directed = 0;
  logic [23:0] bar_seen [0:15];
  logic [23:0] chk_00 = 24'h5A5A5A, chk_20 = 24'h5A5A5A;
  int          first_de = 0, cnt_hs = 0, cnt_vs = 0, cnt_de = 0, last_fs = 0;

  int          pos, h, v, f, x, y;
  logic        e_de, e_hs, e_vs;
  logic [23:0] e_rgb, a_rgb;

  always @(negedge clk) begin
    if (rst_n && n_edge >= 1) begin
      if (n_edge == 1) begin
        f = 0; x = 0; y = 0; e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_rgb = '0;
      end else begin
        pos  = (n_edge - 2) % FT;
        f    = (n_edge - 2) / FT;
        h    = pos % HT;
        v    = pos / HT;
        e_de = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
        e_hs = !(h < HS);
        e_vs = !(v < VS);
        x    = e_de ? h - HS - HB : 0;
        y    = e_de ? v - VS - VB : 0;
        e_rgb = (e_de && disp_s) ? pat(mode_of[f], x, y, solid_of[f], f) : 24'h0;
      end
      a_rgb = {lcd.lcd_r, lcd.lcd_g, lcd.lcd_b};
      chk("rgb", a_rgb, e_rgb);
      chk("de", lcd.lcd_de, e_de);
      chk("hsync", lcd.lcd_hsync, e_hs);
      chk("vsync", lcd.lcd_vsync, e_vs);
      chk("pixel_x", pixel_x, x);
      chk("pixel_y", pixel_y, y);
      chk("frame_start", frame_start, ((n_edge - 1) % FT == 0));
      chk("frame_cnt", frame_cnt, 16'((n_edge - 1) / FT + 1));
      chk("lcd_disp", lcd.lcd_disp, disp_s);
      chk("lcd_dclk", lcd.lcd_dclk, 1'b1);

      if (frame_start) begin
        if (n_edge != 1) chk("fs_period", n_edge - last_fs, FT);
        last_fs = n_edge;
      end
      if (directed != 0) begin
        if (lcd.lcd_de && first_de == 0) first_de = n_edge;
        if (f == 0 && e_de && y == 3) bar_seen[x] = a_rgb;
        if (f == 1 && e_de && y == 0 && x == 0) chk_00 = a_rgb;
        if (f == 1 && e_de && y == 0 && x == 2) chk_20 = a_rgb;
        if (f == 3 && n_edge >= 2) begin
          if (!lcd.lcd_hsync) cnt_hs++;
          if (!lcd.lcd_vsync) cnt_vs++;
          if (lcd.lcd_de)     cnt_de++;
        end
      end
    end
  end

  task automatic wait_edge(input int k);
    int g;
    g = 0;
    while (n_edge < k && g < 20000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (n_edge < k) chk("wait_edge_timeout", n_edge, k);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_rgb"}, {lcd.lcd_r, lcd.lcd_g, lcd.lcd_b}, 24'h0);
    chk({tag, "_de"}, lcd.lcd_de, 1'b0);
    chk({tag, "_hsync"}, lcd.lcd_hsync, 1'b1);
    chk({tag, "_vsync"}, lcd.lcd_vsync, 1'b1);
    chk({tag, "_disp"}, lcd.lcd_disp, 1'b0);
    chk({tag, "_px"}, pixel_x, 11'd0);
    chk({tag, "_py"}, pixel_y, 10'd0);
    chk({tag, "_fs"}, frame_start, 1'b0);
    chk({tag, "_fcnt"}, frame_cnt, 16'd0);
  endtask

  task automatic random_cycles(input int ncyc);
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 149) == 0) mode = 2'($urandom_range(0, 3));
      disp_en = ($urandom_range(0, 23) != 0);
      if ($urandom_range(0, 63) == 0) solid_rgb = 24'($urandom);
    end
  endtask

  int n0, g;

  initial begin
    #1 rst_n = 1'b0;
    #2 check_reset_state("reset0");
    @(posedge clk);
    #1;
    directed = 1;
    rst_n = 1'b1;

    wait_edge(1);
    chk("first_frame_start", frame_start, 1'b1);
    chk("first_frame_cnt", frame_cnt, 16'd1);

    wait_edge(80);
    mode = 2'd2;
    wait_edge(250);
    mode = 2'd3;
    solid_rgb = 24'h123456;

    n0 = 2 * FT + 3 * HT + 10;
    wait_edge(n0);
    chk("solid_pixel", {lcd.lcd_r, lcd.lcd_g, lcd.lcd_b}, 24'h123456);
    disp_en = 1'b0;
    wait_edge(n0 + 2);
    chk("blank_rgb", {lcd.lcd_r, lcd.lcd_g, lcd.lcd_b}, 24'h000000);
    chk("blank_disp", lcd.lcd_disp, 1'b0);
    chk("blank_de", lcd.lcd_de, 1'b1);
    chk("blank_hsync", lcd.lcd_hsync, 1'b1);
    wait_edge(n0 + 8);
    disp_en = 1'b1;

    wait_edge(4 * FT + 2);
    chk("first_de_edge", first_de, 53);
    chk("bar_x0", bar_seen[0], 24'hFFFFFF);
    chk("bar_x4", bar_seen[4], 24'hFFFFFF);
    chk("bar_x5", bar_seen[5], 24'hFFFF00);
    chk("bar_x9", bar_seen[9], 24'hFFFF00);
    chk("bar_x10", bar_seen[10], 24'h00FFFF);
    chk("bar_x15", bar_seen[15], 24'h00FFFF);
    chk("checker_0_0", chk_00, 24'h000000);
    chk("checker_2_0", chk_20, 24'hFFFFFF);
    chk("hsync_low_per_frame", cnt_hs, 21);
    chk("vsync_low_per_frame", cnt_vs, 23);
    chk("de_high_per_frame", cnt_de, 64);
    directed = 0;

    random_cycles(8 * FT);

    g = 0;
    while (lcd.lcd_de !== 1'b1 && g < 2 * FT) begin
      @(negedge clk);
      g++;
    end
    chk("midline_de_found", lcd.lcd_de, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_state("midreset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_edge(1);
    chk("restart_frame_start", frame_start, 1'b1);
    chk("restart_frame_cnt", frame_cnt, 16'd1);

    random_cycles(4 * FT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
